ntm_accumulator: RTL

Frame accumulator sitting directly downstream of `ntm_design`. It consumes the 9-bit `out` sum stream over a valid/ready handshake and adds `COUNT` consecutive samples into one wider frame total. It then presents the total, with its sample count, on a valid/ready output port. A `flush` input closes a partial frame early.

---
 rtl/ntm_accumulator_pkg.sv | 16 +
 rtl/ntm_accumulator_if.sv | 34 +++
 rtl/ntm_accumulator.sv | 102 ++++++++++
 3 files changed

// File: rtl/ntm_accumulator_pkg.sv
// ntm_accumulator_pkg
// Holds the shared definitions for the frame accumulator that sits after ntm_design:
//   - NTM_DATA_W : default sample width, which is the width of ntm_design.out.
//   - NTM_COUNT  : default number of samples in one full frame.
//   - ntm_acc_state_t : control states. ACCUM builds a frame; HOLD presents a result.
package ntm_accumulator_pkg;

  localparam int NTM_DATA_W = 9;
  localparam int NTM_COUNT  = 4;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } ntm_acc_state_t;

endpackage

// File: rtl/ntm_accumulator_if.sv
// ntm_accumulator_if
// Carries the sample stream into the frame accumulator and the frame result out of it.
//   Input side  : in_valid, in_ready, in_data[DATA_W], flush
//   Output side : out_valid, out_ready, out_data[ACC_W], out_count[CNT_W]
// Modports:
//   slave  : the accumulator's own view of the bus.
//   master : the view of the producer and consumer that surround the accumulator.
interface ntm_accumulator_if #(
  parameter int DATA_W = ntm_accumulator_pkg::NTM_DATA_W,
  parameter int COUNT  = ntm_accumulator_pkg::NTM_COUNT,
  parameter int ACC_W  = DATA_W + $clog2(COUNT),
  parameter int CNT_W  = $clog2(COUNT + 1)
);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_data;
  logic [CNT_W-1:0]  out_count;

  modport slave (
    input  in_valid, in_data, flush, out_ready,
    output in_ready, out_valid, out_data, out_count
  );

  modport master (
    output in_valid, in_data, flush, out_ready,
    input  in_ready, out_valid, out_data, out_count
  );

endinterface

// File: rtl/ntm_accumulator.sv
// ntm_accumulator
// Adds COUNT consecutive unsigned samples into one frame total. The total and its
// sample count are then held on a valid/ready output until the consumer takes them.
// The flush input closes a partial frame early.
// Ports:
//   clk : the rising-edge clock.
//   rst : synchronous reset, active high. It discards the partial frame and any pending result.
//   bus : the ntm_accumulator_if slave modport. It carries the sample input and the frame output.
module ntm_accumulator
  import ntm_accumulator_pkg::*;
#(
  parameter int DATA_W = NTM_DATA_W,
  parameter int COUNT  = NTM_COUNT,
  parameter int ACC_W  = DATA_W + $clog2(COUNT),
  parameter int CNT_W  = $clog2(COUNT + 1)
) (
  input  logic                clk,
  input  logic                rst,
  ntm_accumulator_if.slave    bus
);

  ntm_acc_state_t   state_p0, state_nxt;
  logic [ACC_W-1:0] acc_p0, acc_nxt, sum;
  logic [CNT_W-1:0] cnt_p0, cnt_nxt, cnt_inc;
  logic [ACC_W-1:0] out_data_p1, out_data_nxt;
  logic [CNT_W-1:0] out_count_p1, out_count_nxt;
  logic             accept, emit, close;

  // Zero-extends a sample to the accumulator width. ACC_W leaves room for COUNT
  // full-scale samples, so the sum never needs saturation.
  function automatic logic [ACC_W-1:0] zext(input logic [DATA_W-1:0] d);
    return {{(ACC_W-DATA_W){1'b0}}, d};
  endfunction

  // In HOLD, the block can take a new sample only in the cycle where the result leaves.
  // The new sample then starts the next frame, so back-to-back frames have no bubble.
  assign bus.in_ready  = rst ? 1'b0 : ((state_p0 == ACCUM) ? 1'b1 : bus.out_ready);
  assign bus.out_valid = (state_p0 == HOLD);
  assign bus.out_data  = out_data_p1;
  assign bus.out_count = out_count_p1;

  assign accept  = bus.in_valid & bus.in_ready;
  assign emit    = bus.out_valid & bus.out_ready;
  assign sum     = acc_p0 + zext(bus.in_data);
  assign cnt_inc = cnt_p0 + CNT_W'(1);
  // A flush closes the frame only if the frame would hold at least one sample.
  assign close   = (accept && (cnt_inc == CNT_W'(COUNT))) ||
                   (bus.flush && ((cnt_p0 != '0) || accept));

  always_comb begin
    state_nxt     = state_p0;
    acc_nxt       = acc_p0;
    cnt_nxt       = cnt_p0;
    out_data_nxt  = out_data_p1;
    out_count_nxt = out_count_p1;
    case (state_p0)
      ACCUM: begin
        if (accept) begin
          acc_nxt = sum;
          cnt_nxt = cnt_inc;
        end
        if (close) begin
          out_data_nxt  = accept ? sum : acc_p0;
          out_count_nxt = accept ? cnt_inc : cnt_p0;
          acc_nxt       = '0;
          cnt_nxt       = '0;
          state_nxt     = HOLD;
        end
      end
      HOLD: begin
        // Flush is ignored here. A sample accepted during the emit always opens a new frame.
        if (emit) begin
          state_nxt = ACCUM;
          acc_nxt   = accept ? zext(bus.in_data) : '0;
          cnt_nxt   = accept ? CNT_W'(1) : '0;
        end
      end
      default: state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_p0 <= ACCUM;
    else     state_p0 <= state_nxt;
  end

  // p0: running frame sum and count; p1: output register for the closed frame
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_p0       <= '0;
      cnt_p0       <= '0;
      out_data_p1  <= '0;
      out_count_p1 <= '0;
    end else begin
      acc_p0       <= acc_nxt;
      cnt_p0       <= cnt_nxt;
      out_data_p1  <= out_data_nxt;
      out_count_p1 <= out_count_nxt;
    end
  end

endmodule
